// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES load sequencer: data width, default timing
// constants and the controller state encoding.
package aes_ctrl_pkg;

  localparam int AES_DATA_W          = 128;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_TIMEOUT_CYCLES  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ctrl_state_e;

  function automatic logic is_busy(input ctrl_state_e s);
    return s inside {ST_LOAD, ST_START, ST_WAIT};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, giving the intended shift-register behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/aes_load_ctrl.sv
// Sequencer between the push-button/operand sources and the AES core:
// captures operands, pulses start, waits for done with timeout, holds result.
module aes_load_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W          = AES_DATA_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              press,
  input  logic [DATA_W-1:0] i_plaintext,
  input  logic [DATA_W-1:0] i_key,
  input  logic [DATA_W-1:0] i_iv,
  input  logic              i_core_done,
  input  logic [DATA_W-1:0] i_core_result,
  output logic [DATA_W-1:0] o_plaintext,
  output logic [DATA_W-1:0] o_key,
  output logic [DATA_W-1:0] o_iv,
  output logic              o_start,
  output logic [DATA_W-1:0] o_result,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_next;
  logic              w_event;
  logic              w_to_hit;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_plaintext;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_iv;
  logic [DATA_W-1:0] r_result;
  logic              r_start;
  logic              r_valid;
  logic              r_busy;
  logic              r_timeout;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (press),
    .o_rise (w_event)
  );

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; a path that left w_state_next unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_event) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_START;
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_core_done)   w_state_next = ST_DONE;
        else if (w_to_hit) w_state_next = ST_ERR;
      end
      ST_DONE,
      ST_ERR:   if (w_event) w_state_next = ST_LOAD;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_plaintext <= '0;
      r_key       <= '0;
      r_iv        <= '0;
      r_result    <= '0;
      r_start     <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_start <= (w_state_next == ST_START);
      r_busy  <= is_busy(w_state_next);

      if (w_state_next == ST_LOAD) begin
        r_plaintext <= i_plaintext;
        r_key       <= i_key;
        r_iv        <= i_iv;
        r_valid     <= 1'b0;
        r_timeout   <= 1'b0;
      end

      // Done has priority over the timeout terminal count.
      if (r_state == ST_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
        if (i_core_done) begin
          r_result <= i_core_result;
          r_valid  <= 1'b1;
        end else if (w_to_hit) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_plaintext = r_plaintext;
  assign o_key       = r_key;
  assign o_iv        = r_iv;
  assign o_start     = r_start;
  assign o_result    = r_result;
  assign o_valid     = r_valid;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Scoreboard bench for aes_load_ctrl: directed presses push expected events,
// a monitor pops and compares them as o_start/o_valid/o_timeout appear.
module tb_aes_load_ctrl;

  localparam int W  = 128;
  localparam int DB = 4;
  localparam int TO = 16;

  localparam logic [W-1:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] V1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [W-1:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [W-1:0] P2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [W-1:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] V2 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [W-1:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [W-1:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] R3 = 128'ha5a5a5a55a5a5a5a0123456789abcdef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         press = 1'b0;
  logic [W-1:0] i_plaintext = '0;
  logic [W-1:0] i_key = '0;
  logic [W-1:0] i_iv = '0;
  logic         i_core_done = 1'b0;
  logic [W-1:0] i_core_result = '0;
  logic [W-1:0] o_plaintext, o_key, o_iv, o_result;
  logic         o_start, o_valid, o_busy, o_timeout;

  aes_load_ctrl #(
    .DATA_W          (W),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .press         (press),
    .i_plaintext   (i_plaintext),
    .i_key         (i_key),
    .i_iv          (i_iv),
    .i_core_done   (i_core_done),
    .i_core_result (i_core_result),
    .o_plaintext   (o_plaintext),
    .o_key         (o_key),
    .o_iv          (o_iv),
    .o_start       (o_start),
    .o_result      (o_result),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_NONE, EV_START, EV_RESULT, EV_TIMEOUT} ev_e;
  typedef struct {
    ev_e          kind;
    logic [W-1:0] pt;
    logic [W-1:0] key;
    logic [W-1:0] iv;
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Core model controls, written only by the main stimulus process.
  logic         core_en  = 1'b0;
  int           core_lat = 0;
  logic [W-1:0] core_res = '0;
  int           stray_req = 0;
  int           stray_ack = 0;

  // Monitor state, written only by the monitor process.
  int   mon_cyc = 0;
  int   mon_start_cyc = 0;
  logic mon_pv = 1'b0;
  logic mon_pto = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] out_flags();
    return {o_start, o_valid, o_busy, o_timeout, |o_plaintext, |o_key, |o_iv, |o_result};
  endfunction

  task automatic push_start(input logic [W-1:0] pt, input logic [W-1:0] key, input logic [W-1:0] iv);
    exp_t e;
    e.kind = EV_START; e.pt = pt; e.key = key; e.iv = iv; e.res = '0; e.lat = 0;
    sb_q.push_back(e);
  endtask

  task automatic push_end(input ev_e kind, input logic [W-1:0] res, input int lat);
    exp_t e;
    e.kind = kind; e.pt = '0; e.key = '0; e.iv = '0; e.res = res; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_e kind, input int lat);
    exp_t e;
    ev_e  ek;
    ek = (sb_q.size() > 0) ? sb_q[0].kind : EV_NONE;
    check("event_kind", W'(kind), W'(ek));
    if (sb_q.size() > 0 && ek == kind) begin
      e = sb_q.pop_front();
      case (kind)
        EV_START: begin
          check("start_pt", o_plaintext, e.pt);
          check("start_key", o_key, e.key);
          check("start_iv", o_iv, e.iv);
          check("start_busy", W'(o_busy), W'(1));
        end
        EV_RESULT: begin
          check("result_data", o_result, e.res);
          check("result_latency", W'(lat), W'(e.lat));
          check("result_no_timeout", W'(o_timeout), W'(0));
        end
        default: begin
          check("timeout_latency", W'(lat), W'(e.lat));
          check("timeout_no_valid", W'(o_valid), W'(0));
        end
      endcase
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (o_start) begin
        mon_start_cyc = mon_cyc;
        observe(EV_START, 0);
      end
      if (o_valid && !mon_pv)    observe(EV_RESULT, mon_cyc - mon_start_cyc);
      if (o_timeout && !mon_pto) observe(EV_TIMEOUT, mon_cyc - mon_start_cyc);
      mon_pv  = o_valid;
      mon_pto = o_timeout;
    end
  end

  // AES core model: done pulse core_lat cycles after o_start, plus stray pulses on request.
  initial begin
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack++;
        i_core_result = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        i_core_done   = 1'b1;
        @(negedge clk);
        i_core_done   = 1'b0;
      end else if (o_start && core_en) begin
        repeat (core_lat) @(negedge clk);
        i_core_result = core_res;
        i_core_done   = 1'b1;
        @(negedge clk);
        i_core_done   = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic press_for(input int n);
    press = 1'b1;
    tick(n);
    press = 1'b0;
  endtask

  function automatic logic flag(input int sel);
    case (sel)
      0:       return o_start;
      1:       return o_busy;
      2:       return o_valid;
      default: return o_timeout;
    endcase
  endfunction

  task automatic wait_flag(input int sel, input int max, input string name);
    for (int n = 0; n < max && !flag(sel); n++) @(negedge clk);
    check(name, W'(flag(sel)), W'(1));
  endtask

  initial begin
    // 1: reset, idle without a press
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_outputs_zero", W'(out_flags()), W'(0));
    end

    // 2: nominal operation with known-answer vectors
    i_plaintext = P1; i_key = K1; i_iv = V1;
    core_en = 1'b1; core_lat = 11; core_res = R1;
    push_start(P1, K1, V1);
    push_end(EV_RESULT, R1, 12);
    press = 1'b1;
    wait_flag(1, 20, "wait_busy_op1");
    check("load_no_start", W'(o_start), W'(0));
    check("load_pt", o_plaintext, P1);
    check("load_key", o_key, K1);
    tick(1);
    check("start_pulse", W'(o_start), W'(1));
    tick(1);
    check("start_single", W'(o_start), W'(0));
    tick(6);
    press = 1'b0;
    wait_flag(2, 30, "wait_valid_op1");
    i_plaintext = P2; i_key = K2; i_iv = V2;
    tick(5);
    check("hold_pt", o_plaintext, P1);
    check("hold_key", o_key, K1);
    check("hold_iv", o_iv, V1);
    check("hold_result", o_result, R1);
    check("hold_valid", W'(o_valid), W'(1));
    check("done_not_busy", W'(o_busy), W'(0));
    tick(12);

    // 3: glitches rejected, 5-cycle hold accepted
    do_reset();
    check("reset_outputs_zero", W'(out_flags()), W'(0));
    for (int g = 1; g <= 3; g++) begin
      press_for(g);
      tick(8);
      check("glitch_idle", W'(out_flags()), W'(0));
    end
    core_lat = 3; core_res = R2;
    push_start(P2, K2, V2);
    push_end(EV_RESULT, R2, 4);
    press_for(5);
    wait_flag(0, 20, "wait_start_hold5");
    wait_flag(2, 30, "wait_valid_hold5");
    check("hold5_result", o_result, R2);
    tick(12);

    // 4: core never answers, then retry with fresh operands
    core_en = 1'b0;
    push_start(P2, K2, V2);
    push_end(EV_TIMEOUT, '0, 17);
    press_for(6);
    wait_flag(3, 40, "wait_timeout");
    check("err_not_busy", W'(o_busy), W'(0));
    tick(12);
    check("timeout_sticky", W'(o_timeout), W'(1));
    i_plaintext = P3; i_key = K1; i_iv = V1;
    core_en = 1'b1; core_lat = 5; core_res = R3;
    push_start(P3, K1, V1);
    push_end(EV_RESULT, R3, 6);
    press = 1'b1;
    wait_flag(1, 20, "wait_busy_retry");
    check("retry_timeout_cleared", W'(o_timeout), W'(0));
    check("retry_fresh_pt", o_plaintext, P3);
    tick(4);
    press = 1'b0;
    wait_flag(2, 30, "wait_valid_retry");
    check("retry_result", o_result, R3);
    tick(12);

    // 5: stray done in IDLE, press during WAIT, done on the timeout terminal
    do_reset();
    stray_req++;
    tick(4);
    check("stray_done_ignored", W'(out_flags()), W'(0));
    core_lat = 14; core_res = R1;
    push_start(P3, K1, V1);
    push_end(EV_RESULT, R1, 15);
    press_for(6);
    wait_flag(0, 20, "wait_start_drop");
    press_for(6);
    wait_flag(2, 30, "wait_valid_drop");
    check("drop_result", o_result, R1);
    tick(12);
    core_lat = 16; core_res = R2;
    push_start(P3, K1, V1);
    push_end(EV_RESULT, R2, 17);
    press_for(6);
    wait_flag(0, 20, "wait_start_edge");
    wait_flag(2, 40, "wait_valid_edge");
    check("edge_timeout_low", W'(o_timeout), W'(0));
    check("edge_result", o_result, R2);
    tick(12);

    // 6: reset in the middle of WAIT; the late done must be ignored
    core_lat = 10; core_res = R3;
    push_start(P3, K1, V1);
    press_for(6);
    wait_flag(0, 20, "wait_start_rst");
    tick(4);
    check("mid_wait_busy", W'(o_busy), W'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_outputs_zero", W'(out_flags()), W'(0));
    tick(12);
    check("late_done_ignored", W'(out_flags()), W'(0));

    tick(5);
    check("scoreboard_drained", W'(sb_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
